ldst_initiator: RTL and testbench

LDST_INITIATOR -- requirements
Module: ldst_initiator

---
 rtl/ldst_initiator.sv | 150 +++++++++++++++
 tb/tb_ldst_initiator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_initiator.sv
// ldst_initiator
//   Turns a single 64-bit load/store request from the pipeline memory stage
//   into eight sequential byte accesses on a 256-byte data memory.
//   Stores are big-endian: the most significant byte goes to the lowest address.
//   Loads assemble the bytes in the same order. A one-cycle response pulse
//   follows the eighth beat.
//
//   Optional feature: define ALIGN_CHECK_EN to reject requests whose address
//   is not doubleword aligned or lies above the 256-byte memory. A rejected
//   request answers in the cycle after acceptance with o_rsp_err=1. It makes
//   no memory access and leaves o_rsp_rdata unchanged.
//
// Ports
//   i_clock      : clock, all state changes on the rising edge
//   i_reset      : asynchronous active-high reset
//   i_req_valid  : request present
//   i_req_write  : 1 = store doubleword, 0 = load doubleword
//   i_req_addr   : byte address of the doubleword
//   i_req_wdata  : store data
//   o_req_ready  : request accepted when i_req_valid & o_req_ready at an edge
//   o_busy       : pipeline stall, high whenever not idle
//   o_rsp_valid  : one-cycle completion pulse
//   o_rsp_rdata  : assembled load data, held between loads
//   o_rsp_err    : request rejected, qualified by o_rsp_valid
//   o_mem_addr   : byte address into the data memory
//   o_mem_wdata  : byte to write
//   o_mem_we     : byte write strobe
//   o_mem_re     : byte read strobe
//   i_mem_rdata  : read byte, combinational from o_mem_addr
module ldst_initiator (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic        i_req_write,
    input  logic [63:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_busy,
    output logic        o_rsp_valid,
    output logic [63:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [7:0]  o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    output logic        o_mem_we,
    output logic        o_mem_re,
    input  logic [7:0]  i_mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [2:0]  r_beat;
    logic [7:0]  r_addr;
    logic [63:0] r_wdata;
    logic        r_write;
    // Only the first seven bytes are held here. The eighth byte comes straight
    // from i_mem_rdata when the result is committed to r_rdata.
    logic [55:0] r_shift;
    logic [63:0] r_rdata;

    logic        w_accept;
    logic        w_misalign;
    logic        w_xfer;
    logic [2:0]  w_sel;

    assign w_accept = i_req_valid && (r_state == S_IDLE);

`ifdef ALIGN_CHECK_EN
    logic r_err;

    assign w_misalign = (i_req_addr[2:0] != 3'd0) || (i_req_addr[63:8] != 56'd0);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misalign;
        end
    end

    assign o_rsp_err = o_rsp_valid && r_err;
`else
    // Without the check, address bits above the memory are ignored and
    // addresses wrap modulo 256.
    logic w_unused_addr;
    assign w_unused_addr = ^i_req_addr[63:8];
    assign w_misalign    = 1'b0;
    assign o_rsp_err     = 1'b0;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_shift <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= i_req_addr[7:0];
                        r_wdata <= i_req_wdata;
                        r_write <= i_req_write;
                        r_beat  <= '0;
                        r_state <= w_misalign ? S_RESP : S_XFER;
                    end
                end
                S_XFER: begin
                    if (!r_write) begin
                        r_shift <= {r_shift[47:0], i_mem_rdata};
                    end
                    if (r_beat == 3'd7) begin
                        if (!r_write) begin
                            r_rdata <= {r_shift, i_mem_rdata};
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_beat <= r_beat + 3'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_xfer      = (r_state == S_XFER);
    // Beat i carries byte wdata[63-8i -: 8]. This is the same as slice 7-i
    // counted from the least significant end.
    assign w_sel       = 3'd7 - r_beat;

    assign o_req_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_rdata = r_rdata;
    assign o_mem_we    = w_xfer && r_write;
    assign o_mem_re    = w_xfer && !r_write;
    assign o_mem_addr  = w_xfer ? (r_addr + {5'd0, r_beat}) : '0;
    assign o_mem_wdata = (w_xfer && r_write) ? r_wdata[{w_sel, 3'b000} +: 8] : '0;

endmodule

// File: tb/tb_ldst_initiator.sv
module tb_ldst_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        i_req_write = 1'b0;
    logic [63:0] i_req_addr  = '0;
    logic [63:0] i_req_wdata = '0;
    logic        o_req_ready, o_busy, o_rsp_valid, o_rsp_err;
    logic [63:0] o_rsp_rdata;
    logic [7:0]  o_mem_addr, o_mem_wdata, mem_rdata;
    logic        o_mem_we, o_mem_re;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    ldst_initiator dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_req_valid (i_req_valid),
        .i_req_write (i_req_write),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_req_ready (o_req_ready),
        .o_busy      (o_busy),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_we    (o_mem_we),
        .o_mem_re    (o_mem_re),
        .i_mem_rdata (mem_rdata)
    );

    // Environment memory: combinational read, write on rising edge
    assign mem_rdata = mem[o_mem_addr];
    always @(posedge clk) if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    // ph = number of edges since acceptance: 1..8 = beat ph-1, 9 = response, 0 = idle
    int          ph = 0;
    bit          m_w, m_err;
    logic [7:0]  m_a;
    logic [63:0] m_d;
    logic [63:0] m_rdata = '0;

    function automatic bit misaligned(input logic [63:0] a);
`ifdef ALIGN_CHECK_EN
        return (a[2:0] != 3'd0) || (a[63:8] != 56'd0);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph      = 0;
            m_err   = 1'b0;
            m_rdata = '0;
        end else if (ph == 0) begin
            if (i_req_valid) begin
                m_w   = i_req_write;
                m_a   = i_req_addr[7:0];
                m_d   = i_req_wdata;
                m_err = misaligned(i_req_addr);
                ph    = m_err ? 9 : 1;
            end
        end else if (ph <= 8) begin
            if (m_w) ref_mem[8'(m_a + ph - 1)] = 8'(m_d >> (8 * (8 - ph)));
            if (ph == 8 && !m_w) begin
                logic [63:0] v;
                v = '0;
                for (int k = 0; k < 8; k++) v = {v[55:0], ref_mem[8'(m_a + k)]};
                m_rdata = v;
            end
            ph++;
        end else begin
            ph = 0;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_on) begin
            bit x;
            x = (ph >= 1) && (ph <= 8);
            chk("req_ready", o_req_ready, ph == 0);
            chk("busy",      o_busy,      ph != 0);
            chk("rsp_valid", o_rsp_valid, ph == 9);
            chk("rsp_err",   o_rsp_err,   (ph == 9) && m_err);
            chk("rsp_rdata", o_rsp_rdata, m_rdata);
            chk("mem_we",    o_mem_we,    x && m_w);
            chk("mem_re",    o_mem_re,    x && !m_w);
            chk("mem_addr",  o_mem_addr,  x ? 8'(m_a + ph - 1) : 8'd0);
            chk("mem_wdata", o_mem_wdata, (x && m_w) ? 8'(m_d >> (8 * (8 - ph))) : 8'd0);
        end
    end

    // ---------------- stimulus ----------------
    // Issue one request; returns cycles from accept to rsp_valid and busy cycles seen.
    task automatic do_req(input bit w, input logic [63:0] a, input logic [63:0] d,
                          output int lat, output int busy_n);
        bit ok;
        @(posedge clk); #2;
        i_req_valid = 1'b1; i_req_write = w; i_req_addr = a; i_req_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("accept");
        @(posedge clk); #2;
        i_req_valid = 1'b0;
        lat = 0; busy_n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (o_busy) busy_n++;
            if (o_rsp_valid) begin lat = i; break; end
        end
        if (lat == 0) timeout("rsp_valid");
    endtask

    task automatic poke(input int adr, input logic [7:0] v);
        mem[adr] = v;
        ref_mem[adr] = v;
    endtask

    initial begin
        int lat, bn, gap;
        bit ok;
        for (int k = 0; k < 256; k++) poke(k, 8'(k * 7 + 3));
        for (int k = 16; k < 24; k++) poke(k, 8'h22);

        repeat (2) @(posedge clk);
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset req_ready", o_req_ready, 1'b1);
        chk("reset rsp_rdata", o_rsp_rdata, 64'd0);

        // Load from 16
        do_req(1'b0, 64'd16, 64'd0, lat, bn);
        chk("load16 latency", lat, 9);
        chk("load16 busy cycles", bn, 9);
        chk("load16 rdata", o_rsp_rdata, 64'h2222222222222222);

        // Store then load at 8
        do_req(1'b1, 64'd8, 64'h0123456789ABCDEF, lat, bn);
        chk("store8 latency", lat, 9);
        chk("store8 rdata kept", o_rsp_rdata, 64'h2222222222222222);
        chk("store8 byte8", mem[8], 8'h01);
        chk("store8 byte15", mem[15], 8'hEF);
        do_req(1'b0, 64'd8, 64'd0, lat, bn);
        chk("load8 rdata", o_rsp_rdata, 64'h0123456789ABCDEF);

        // Two loads with req_valid held high
        @(posedge clk); #2;
        i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = 64'd16;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("b2b accept");
        @(posedge clk);
        gap = 0; bn = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (o_req_ready) begin gap = i; break; end
            if (o_busy) bn++;
        end
        chk("b2b second accept cycle", gap, 10);
        chk("b2b busy cycles", bn, 9);
        @(posedge clk); #2 i_req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_rsp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("b2b second rsp");
        chk("b2b rdata", o_rsp_rdata, 64'h2222222222222222);

`ifdef ALIGN_CHECK_EN
        do_req(1'b0, 64'd3, 64'd0, lat, bn);
        chk("misaligned latency", lat, 1);
        chk("misaligned err", o_rsp_err, 1'b1);
        chk("misaligned rdata kept", o_rsp_rdata, 64'h2222222222222222);
`else
        do_req(1'b1, 64'd252, 64'h1122334455667788, lat, bn);
        chk("wrap byte252", mem[252], 8'h11);
        chk("wrap byte255", mem[255], 8'h44);
        chk("wrap byte0", mem[0], 8'h55);
        chk("wrap byte3", mem[3], 8'h88);
`endif

        // Reset during beat 4 of a store
        @(posedge clk); #2;
        for (int k = 0; k < 8; k++) poke(k, 8'h5A);
        i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 64'd0; i_req_wdata = '1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("abort accept");
        @(posedge clk); #2 i_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("abort beat4 we", o_mem_we, 1'b1);
        chk("abort beat4 addr", o_mem_addr, 8'd4);
        #1 rst = 1'b1;
        #1;
        chk("abort we dropped", o_mem_we, 1'b0);
        chk("abort busy", o_busy, 1'b0);
        @(posedge clk); #2 rst = 1'b0;
        for (int k = 0; k < 8; k++) chk("abort mem", mem[k], (k < 4) ? 8'hFF : 8'h5A);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_rsp_valid) ok = 1'b1;
        end
        chk("abort no rsp_valid", ok, 1'b0);

        // Randomised traffic; req_* may toggle freely while busy
        for (int c = 0; c < 900; c++) begin
            logic [63:0] a;
            @(posedge clk); #2;
            a = {$urandom, $urandom};
            if ($urandom_range(3) != 0) a[63:8] = '0;
            if ($urandom_range(1) != 0) a[2:0] = '0;
            i_req_valid = ($urandom_range(3) == 0);
            i_req_write = $urandom_range(1) != 0;
            i_req_addr  = a;
            i_req_wdata = {$urandom, $urandom};
        end
        @(posedge clk); #2 i_req_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        for (int k = 0; k < 256; k++) chk("final mem", mem[k], ref_mem[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
